// File: rtl/tdc_measure_ctrl.sv
`timescale 1ns/1ps
// tdc_measure_ctrl: measurement sequencer for the tapped-delay-line TDC.
// Fires the TDC start pulse and counts coarse cycles until a synchronized
// stop edge arrives. After a settle window it samples the fine code and
// returns a {coarse, fine} result, with timeout and abort handling.
//
// Result handshake: result_o/timeout_o are held stable while result_valid_o
// is high. A transfer happens on any clock edge where result_valid_o and
// result_ready_i are both high. result_valid_o never drops without a transfer
// except on reset.
module tdc_measure_ctrl #(
    parameter int NUM_TAPS       = 32,
    parameter int COARSE_W       = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int SETTLE_CYCLES  = 2,
    localparam int FINE_W        = $clog2(NUM_TAPS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm_i,
    input  logic                       abort_i,
    input  logic                       stop_i,
    input  logic [FINE_W-1:0]          tdc_fine_i,
    output logic                       tdc_start_o,
    output logic                       busy_o,
    output logic [COARSE_W+FINE_W-1:0] result_o,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic                       timeout_o
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [COARSE_W-1:0] TIMEOUT_LAST = COARSE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD  = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FIRE   = 3'd1,
        COUNT  = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [COARSE_W-1:0]         coarse_q, coarse_d;
    logic [SETTLE_W-1:0]         settle_q, settle_d;
    logic [COARSE_W+FINE_W-1:0]  result_q, result_d;
    logic                        timeout_q, timeout_d;
    logic                        stop_meta_q, stop_meta_d;
    logic                        stop_sync_q, stop_sync_d;
    logic                        stop_prev_q, stop_prev_d;
    logic                        stop_edge;

    // Two-flop synchronizer plus one delay flop for rising-edge detection.
    always_comb begin
        stop_meta_d = stop_i;
        stop_sync_d = stop_meta_q;
        stop_prev_d = stop_sync_q;
        stop_edge   = stop_sync_q & ~stop_prev_q;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            coarse_q    <= '0;
            settle_q    <= '0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
            stop_meta_q <= 1'b0;
            stop_sync_q <= 1'b0;
            stop_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            coarse_q    <= coarse_d;
            settle_q    <= settle_d;
            result_q    <= result_d;
            timeout_q   <= timeout_d;
            stop_meta_q <= stop_meta_d;
            stop_sync_q <= stop_sync_d;
            stop_prev_q <= stop_prev_d;
        end
    end

    // Next-state, counters and result capture; abort only acts before DONE.
    always_comb begin
        state_d   = state_q;
        coarse_d  = coarse_q;
        settle_d  = settle_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (!abort_i && arm_i) state_d = FIRE;
            end
            FIRE: begin
                coarse_d = '0;
                state_d  = abort_i ? IDLE : COUNT;
            end
            COUNT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (stop_edge) begin
                    // Edge beats a same-cycle timeout: coarse freezes here.
                    settle_d = SETTLE_LOAD;
                    state_d  = SETTLE;
                end else if (coarse_q == TIMEOUT_LAST) begin
                    result_d  = {TIMEOUT_LAST, {FINE_W{1'b0}}};
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    coarse_d = coarse_q + 1'b1;
                end
            end
            SETTLE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (settle_q == '0) begin
                    result_d  = {coarse_q, tdc_fine_i};
                    timeout_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            DONE: begin
                if (result_ready_i) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state and result registers.
    always_comb begin
        tdc_start_o    = (state_q == FIRE);
        busy_o         = (state_q != IDLE);
        result_valid_o = (state_q == DONE);
        result_o       = result_q;
        timeout_o      = timeout_q;
    end

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
`timescale 1ns/1ps
// tb_tdc_measure_ctrl: directed bench with an expected-result queue popped
// by a monitor on every result handshake.
module tb_tdc_measure_ctrl;

  localparam int NUM_TAPS = 32;
  localparam int COARSE_W = 16;
  localparam int FINE_W   = 5;
  localparam int TIMEOUT  = 50;
  localparam int SETTLE   = 2;
  localparam int RES_W    = COARSE_W + FINE_W;
  localparam int W        = RES_W + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              arm_i = 1'b0;
  logic              abort_i = 1'b0;
  logic              stop_i = 1'b0;
  logic [FINE_W-1:0] tdc_fine_i = '0;
  logic              tdc_start_o;
  logic              busy_o;
  logic [RES_W-1:0]  result_o;
  logic              result_valid_o;
  logic              result_ready_i = 1'b1;
  logic              timeout_o;

  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  tdc_measure_ctrl #(
    .NUM_TAPS(NUM_TAPS),
    .COARSE_W(COARSE_W),
    .TIMEOUT_CYCLES(TIMEOUT),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arm_i(arm_i),
    .abort_i(abort_i),
    .stop_i(stop_i),
    .tdc_fine_i(tdc_fine_i),
    .tdc_start_o(tdc_start_o),
    .busy_o(busy_o),
    .result_o(result_o),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .timeout_o(timeout_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk_exp(input logic to, input int coarse, input int fine);
    return {to, COARSE_W'(coarse), FINE_W'(fine)};
  endfunction

  // scoreboard monitor: compare on every accepted result
  always @(negedge clk) begin
    if (!rst && result_valid_o && result_ready_i) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_result: got 0x%0h expected none", {timeout_o, result_o});
      end else begin
        check("result", 32'({timeout_o, result_o}), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  // Pulse arm; returns at one cycle after the FIRE cycle (+1 time unit).
  task automatic arm_pulse();
    @(posedge clk); #1;
    check("start_before_arm", 32'(tdc_start_o), 32'd0);
    arm_i = 1'b1;
    @(posedge clk); #1;
    arm_i = 1'b0;
    check("start_pulse", 32'(tdc_start_o), 32'd1);
    check("busy_in_fire", 32'(busy_o), 32'd1);
    @(posedge clk); #1;
    check("start_one_cycle", 32'(tdc_start_o), 32'd0);
  endtask

  // Full measurement with the detected stop edge landing at coarse=target.
  task automatic measure(input int target, input int fine, input int hold);
    logic [W-1:0] e;
    e = mk_exp(1'b0, target, fine);
    tdc_fine_i = FINE_W'(fine);
    result_ready_i = (hold == 0);
    exp_q.push_back(e);
    arm_pulse();
    repeat (target - 2) @(posedge clk);
    #1 stop_i = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("no_valid_before_settle", 32'(result_valid_o), 32'd0);
    end
    @(posedge clk); #1;
    check("valid_after_settle", 32'(result_valid_o), 32'd1);
    check("timeout_clear", 32'(timeout_o), 32'd0);
    for (int i = 0; i < hold; i++) begin
      if (i == 3) arm_i = 1'b1;
      if (i == 4) arm_i = 1'b0;
      @(posedge clk); #1;
      check("hold_valid", 32'(result_valid_o), 32'd1);
      check("hold_no_start", 32'(tdc_start_o), 32'd0);
      check("hold_result", 32'({timeout_o, result_o}), 32'(e));
    end
    result_ready_i = 1'b1;
    @(posedge clk); #1;
    check("valid_dropped", 32'(result_valid_o), 32'd0);
    check("idle_after_done", 32'(busy_o), 32'd0);
    stop_i = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    // reset with arm held high
    arm_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_start", 32'(tdc_start_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
    end
    arm_i = 1'b0;
    check("rst_valid", 32'(result_valid_o), 32'd0);
    check("rst_result", 32'(result_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    rst = 1'b0;
    repeat (6) @(posedge clk);

    // normal measurement
    measure(37, 13, 0);

    // backpressure with an ignored second arm
    measure(22, 6, 20);

    // timeout: no stop, fine input must not leak into result
    tdc_fine_i = 5'd7;
    result_ready_i = 1'b1;
    exp_q.push_back(mk_exp(1'b1, TIMEOUT - 1, 0));
    arm_pulse();
    repeat (49) @(posedge clk);
    #1 check("timeout_not_early", 32'(result_valid_o), 32'd0);
    @(posedge clk); #1;
    check("timeout_valid", 32'(result_valid_o), 32'd1);
    check("timeout_flag", 32'(timeout_o), 32'd1);
    @(posedge clk); #1;
    check("timeout_idle", 32'(busy_o), 32'd0);
    repeat (3) @(posedge clk);

    // stop edge in the last timeout cycle wins
    measure(49, 9, 0);

    // abort in COUNT at coarse=5
    arm_pulse();
    repeat (5) @(posedge clk);
    #1 abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check("abort_idle", 32'(busy_o), 32'd0);
    repeat (10) @(posedge clk);
    #1 check("abort_no_valid", 32'(result_valid_o), 32'd0);
    measure(20, 3, 0);

    // stop pulse while idle has no effect
    @(posedge clk); #1 stop_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 stop_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_stop_busy", 32'(busy_o), 32'd0);
    end

    // sync reset in SETTLE
    tdc_fine_i = 5'd21;
    arm_pulse();
    repeat (35) @(posedge clk);
    #1 stop_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("settle_busy", 32'(busy_o), 32'd1);
    check("settle_valid", 32'(result_valid_o), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_result", 32'(result_o), 32'd0);
    check("midrst_valid", 32'(result_valid_o), 32'd0);
    check("midrst_timeout", 32'(timeout_o), 32'd0);
    rst = 1'b0;
    stop_i = 1'b0;
    repeat (4) @(posedge clk);
    measure(12, 30, 0);

    // final report
    repeat (5) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
